// File: rtl/counter_scheduler.sv
// Round-robin scheduler that time-shares one external 8-bit up-counter among NREQ
// requesters: load a seed, count to the target/overflow/wrap, then report the result.
module counter_scheduler #(
    parameter int NREQ = 4,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   Req,
    input  logic [4*NREQ-1:0] Seed,
    input  logic [8*NREQ-1:0] Target,
    output logic [NREQ-1:0]   Grant,
    output logic              Busy,
    output logic              Done,
    output logic [ID_W-1:0]   DoneId,
    output logic [7:0]        Result,
    output logic              ResultOvf,
    output logic [3:0]        CtrNumberIn,
    output logic              CtrStart,
    input  logic [7:0]        CtrCount,
    input  logic              CtrOverflow
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [3:0]      seed_q, seed_d;
    logic [7:0]      target_q, target_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            done_q, done_d;
    logic [ID_W-1:0] done_id_q, done_id_d;
    logic [7:0]      result_q, result_d;
    logic            result_ovf_q, result_ovf_d;

    logic [ID_W-1:0] win_id;
    logic [NREQ-1:0] win_onehot;
    logic [ID_W-1:0] ptr_after;

    // Scan offsets from the highest down so the lowest offset from the pointer wins.
    always_comb begin
        logic [ID_W:0] idx;
        win_id = '0;
        idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(NREQ)) begin
                idx = idx - (ID_W + 1)'(NREQ);
            end
            if (Req[idx[ID_W-1:0]]) begin
                win_id = idx[ID_W-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_id == ID_W'(gi));
        end
    endgenerate

    assign ptr_after = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        seed_d       = seed_q;
        target_d     = target_q;
        grant_d      = grant_q;
        done_d       = 1'b0;
        done_id_d    = done_id_q;
        result_d     = result_q;
        result_ovf_d = result_ovf_q;

        case (state_q)
            S_IDLE: begin
                if (|Req) begin
                    id_d     = win_id;
                    seed_d   = Seed[4*int'(win_id) +: 4];
                    target_d = Target[8*int'(win_id) +: 8];
                    grant_d  = win_onehot;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // Overflow beats a target match, which beats the FF wrap guard.
                if (CtrOverflow || (CtrCount == target_q) || (CtrCount == 8'hFF)) begin
                    result_d     = CtrCount;
                    result_ovf_d = CtrOverflow || (CtrCount != target_q);
                    done_d       = 1'b1;
                    done_id_d    = id_q;
                    state_d      = S_REPORT;
                end
            end
            default: begin
                grant_d = '0;
                ptr_d   = ptr_after;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            seed_q       <= 4'h0;
            target_q     <= 8'h00;
            grant_q      <= '0;
            done_q       <= 1'b0;
            done_id_q    <= '0;
            result_q     <= 8'h00;
            result_ovf_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            seed_q       <= seed_d;
            target_q     <= target_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            result_q     <= result_d;
            result_ovf_q <= result_ovf_d;
        end
    end

    // The counter has no reset, so it is held loaded with zero whenever no job runs.
    assign CtrStart    = (state_q != S_RUN);
    assign CtrNumberIn = (state_q == S_IDLE) ? 4'h0 : seed_q;
    assign Grant       = grant_q;
    assign Busy        = (state_q != S_IDLE);
    assign Done        = done_q;
    assign DoneId      = done_id_q;
    assign Result      = result_q;
    assign ResultOvf   = result_ovf_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: behavioural counter stand-in plus an in-order
// scoreboard of expected completions checked at every Done pulse.
module tb_counter_scheduler;

    localparam int NREQ = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   Req = '0;
    logic [15:0]  Seed = '0;
    logic [31:0]  Target = '0;
    logic [3:0]   Grant;
    logic         Busy;
    logic         Done;
    logic [1:0]   DoneId;
    logic [7:0]   Result;
    logic         ResultOvf;
    logic [3:0]   CtrNumberIn;
    logic         CtrStart;
    logic [7:0]   CtrCount = 8'h00;
    logic         CtrOverflow = 1'b0;
    logic         ctr_ld15 = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int grant_cnt = 0;
    bit post_done = 0;

    typedef struct {
        int id;
        int seed;
        int res;
        int ovf;
        int cyc;
        int lat;
    } exp_t;
    exp_t sb[$];

    counter_scheduler #(.NREQ(NREQ)) dut (
        .clock       (clock),
        .reset       (reset),
        .Req         (Req),
        .Seed        (Seed),
        .Target      (Target),
        .Grant       (Grant),
        .Busy        (Busy),
        .Done        (Done),
        .DoneId      (DoneId),
        .Result      (Result),
        .ResultOvf   (ResultOvf),
        .CtrNumberIn (CtrNumberIn),
        .CtrStart    (CtrStart),
        .CtrCount    (CtrCount),
        .CtrOverflow (CtrOverflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Counter stand-in: loads {0,seed} on start; a loaded seed of 15 overflows to 0.
    always @(posedge clock) begin
        if (CtrStart) begin
            CtrCount    <= {4'h0, CtrNumberIn};
            CtrOverflow <= 1'b0;
            ctr_ld15    <= (CtrNumberIn == 4'hF);
        end else if (ctr_ld15 && CtrCount == 8'h0F) begin
            CtrCount    <= 8'h00;
            CtrOverflow <= 1'b1;
        end else begin
            CtrCount <= CtrCount + 8'h01;
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input int seed, input int tgt, input int c);
        exp_t e;
        e.id   = id;
        e.seed = seed;
        if (seed == 15 && tgt != 15) begin
            e.res = 0;   e.ovf = 1; e.lat = 4;
        end else if (tgt >= seed) begin
            e.res = tgt; e.ovf = 0; e.lat = 3 + tgt - seed;
        end else begin
            e.res = 255; e.ovf = 1; e.lat = 3 + 255 - seed;
        end
        e.cyc = c + e.lat;
        sb.push_back(e);
    endtask

    task automatic set_job(input int id, input int seed, input int tgt);
        Seed[id*4 +: 4]   = 4'(seed);
        Target[id*8 +: 8] = 8'(tgt);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!Busy && !Done) return;
        end
        check_val("idle_timeout", 0, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (Done) return;
        end
        check_val("done_timeout", 0, 1);
    endtask

    task automatic single(input int id, input int seed, input int tgt);
        wait_idle();
        set_job(id, seed, tgt);
        push_exp(id, seed, tgt, cyc);
        Req = 4'(1 << id);
        wait_done();
        Req = '0;
    endtask

    // Monitor: load/run pin checks, completion checks, and the idle gap after REPORT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (Grant != 0) grant_cnt++;
            else grant_cnt = 0;
            if (post_done) begin
                check_val("gap_busy", int'(Busy), 0);
                check_val("gap_grant", int'(Grant), 0);
                post_done = 0;
            end
            if (grant_cnt == 1 && sb.size() > 0) begin
                check_val("load_numberin", int'(CtrNumberIn), sb[0].seed);
                check_val("load_start", int'(CtrStart), 1);
            end
            if (grant_cnt == 2 && sb.size() > 0) begin
                check_val("run_start", int'(CtrStart), 0);
            end
            if (Done) begin
                post_done = 1;
                if (sb.size() == 0) begin
                    check_val("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("job id=%0d result=%0d ovf=%0d cyc=%0d (exp id=%0d result=%0d ovf=%0d cyc=%0d)",
                             DoneId, Result, ResultOvf, cyc, e.id, e.res, e.ovf, e.cyc);
                    check_val("done_id", int'(DoneId), e.id);
                    check_val("result", int'(Result), e.res);
                    check_val("result_ovf", int'(ResultOvf), e.ovf);
                    check_val("done_cycle", cyc, e.cyc);
                    check_val("report_grant", int'(Grant), 1 << e.id);
                    check_val("grant_len", grant_cnt, e.lat);
                end
            end
        end
    end

    initial begin
        int k;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_val("rst_grant", int'(Grant), 0);
        check_val("rst_busy", int'(Busy), 0);
        check_val("rst_done", int'(Done), 0);
        check_val("rst_doneid", int'(DoneId), 0);
        check_val("rst_result", int'(Result), 0);
        check_val("rst_resultovf", int'(ResultOvf), 0);
        check_val("rst_ctrstart", int'(CtrStart), 1);
        check_val("rst_numberin", int'(CtrNumberIn), 0);
        reset = 1'b0;

        single(1, 3, 10);
        single(0, 15, 40);
        single(0, 15, 15);
        single(2, 5, 2);
        single(3, 9, 255);
        check_val("hold_result", int'(Result), 255);

        // Round robin from a fresh pointer: order 0,1,2,3,0.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wait_idle();
        set_job(0, 2, 2);
        set_job(1, 7, 7);
        set_job(2, 15, 15);
        set_job(3, 0, 0);
        k = cyc;
        for (int j = 0; j < 5; j++) push_exp(j % 4, (j % 4 == 0) ? 2 : (j % 4 == 1) ? 7 : (j % 4 == 2) ? 15 : 0,
                                            (j % 4 == 0) ? 2 : (j % 4 == 1) ? 7 : (j % 4 == 2) ? 15 : 0, k + 4 * j);
        Req = 4'b1111;
        repeat (5) wait_done();
        Req = '0;

        // Fairness: after 3 is served, {0,2} are served 0 then 2.
        single(3, 5, 5);
        wait_idle();
        set_job(0, 3, 8);
        set_job(2, 10, 12);
        k = cyc;
        push_exp(0, 3, 8, k);
        push_exp(2, 10, 12, k + 9);
        Req = 4'b0101;
        wait_done();
        wait_done();
        Req = '0;

        // Reset mid-RUN aborts the job and returns the pointer to 0.
        single(1, 4, 4);
        wait_idle();
        set_job(3, 0, 200);
        Req = 4'b1000;
        @(negedge clock);
        Req = '0;
        repeat (4) @(negedge clock);
        check_val("abort_busy_before", int'(Busy), 1);
        check_val("abort_grant_before", int'(Grant), 8);
        reset = 1'b1;
        @(negedge clock);
        check_val("abort_busy", int'(Busy), 0);
        check_val("abort_grant", int'(Grant), 0);
        check_val("abort_ctrstart", int'(CtrStart), 1);
        check_val("abort_done", int'(Done), 0);
        reset = 1'b0;
        wait_idle();
        set_job(0, 6, 6);
        set_job(2, 1, 1);
        push_exp(0, 6, 6, cyc);
        Req = 4'b0101;
        wait_done();
        Req = '0;
        repeat (10) @(negedge clock);
        check_val("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Round-robin scheduler that shares one 8-bit up-counter datapath (4-bit seed load, start/load control, overflow flag) among NREQ requesters. Each requester posts a 4-bit seed and an 8-bit target. The scheduler grants one job at a time, loads and runs the counter until the target, overflow or 8-bit wrap, then reports the result. It drives the counter's NumberIn/start pins directly and observes Count/Overflow.

## Interface
- NREQ, 4: number of requesters, 2..8.
- clock  input  1  rising-edge clock, shared with the counter.
- reset  input  1  synchronous, active-high.
- Req  input  NREQ  level request per requester.
- Seed  input  4*NREQ  requester i seed at [4i+3:4i].
- Target  input  8*NREQ  requester i target at [8i+7:8i].
- Grant  output  NREQ  one-hot; owner of the counter.
- Busy  output  1  high whenever state != IDLE.
- Done  output  1  one-cycle completion pulse.
- DoneId  output  $clog2(NREQ)  index of the finished job.
- Result  output  8  counter value at termination.
- ResultOvf  output  1  job ended by overflow or wrap, not by a target match.
- CtrNumberIn  output  4  to counter NumberIn.
- CtrStart  output  1  to counter start.
- CtrCount  input  8  from counter Count.
- CtrOverflow  input  1  from counter Overflow.

## Operation
**States:** IDLE, LOAD, RUN, REPORT.

**IDLE**
- CtrStart=1, CtrNumberIn=0. This holds the counter loaded, because the counter has no reset.
- If any Req bit is set, pick a winner by round robin: search from pointer P upward, wrapping mod NREQ.
- Latch the winner's id, Seed and Target, then go to LOAD.
- Seed and Target are sampled only in this cycle.

**LOAD**
- Grant[id]=1, CtrStart=1, CtrNumberIn=latched seed.
- The counter loads {0,seed} at this edge. Go to RUN.

**RUN**
- CtrStart=0, CtrNumberIn held at the seed. Each cycle, evaluate in priority order:
  1. CtrOverflow=1: terminate with ResultOvf=1.
  2. CtrCount==target: terminate with ResultOvf=0.
  3. CtrCount==8'hFF: terminate with ResultOvf=1 (wrap guard).
  4. Otherwise stay in RUN.
- On termination, register Result=CtrCount and go to REPORT.

**REPORT**
- Done=1, DoneId=id. Grant stays high this cycle. CtrStart=1.
- P <= (id+1) mod NREQ. Go to IDLE.

**Other rules**
- Termination is guaranteed. A seed of 15 forces Overflow. Any other seed runs to the target or to 8'hFF within 256 cycles. No watchdog is needed.
- Target < seed is legal. It terminates at 8'hFF with ResultOvf=1.
- Dropping Req mid-job is ignored. Jobs are never aborted.
- Req still high in the IDLE cycle after REPORT counts as a new request.
- Reset values: state IDLE, P=0, Grant=0, Busy=0, Done=0, DoneId=0, Result=0, ResultOvf=0, CtrStart=1, CtrNumberIn=0.
- Reset asserted in any state aborts the job in the same cycle. No Done is issued.
- Result, ResultOvf and DoneId hold their values until the next REPORT.

## Timing
- The request is sampled in IDLE cycle c. LOAD is c+1 and the first RUN cycle is c+2.
- The first RUN cycle sees CtrCount=seed and CtrOverflow=0.
- Target match: Done at c+3+(target-seed).
- seed==target: Done at c+3.
- Seed 15 with target != 15: overflow is seen in the second RUN cycle. Done at c+4, Result=0, ResultOvf=1.
- Seed 15 with target 15: the target matches first. Done at c+3, Result=15, ResultOvf=0.
- Wrap: Done at c+3+(255-seed), Result=8'hFF, ResultOvf=1. Target 8'hFF matches before the wrap guard, so ResultOvf=0.
- Done and Grant are registered outputs. Grant is high from LOAD through REPORT inclusive.
- Back-to-back jobs need at least one IDLE cycle. Minimum job period is 4 cycles.

## Test plan
- **Single target match:** reset, then Req[1]=1, Seed=3, Target=10 → Grant=0b0010 for 10 cycles, Done at c+10, DoneId=1, Result=10, ResultOvf=0.
- **Overflow seed:** Req[0], Seed=15, Target=40 → Done at c+4, Result=0, ResultOvf=1. Seed=15, Target=15 → Done at c+3, Result=15, ResultOvf=0.
- **Wrap:** Req[2], Seed=5, Target=2 → Done at c+253, Result=8'hFF, ResultOvf=1.
- **Round robin:** all Req held high with seed==target → completion order 0,1,2,3,0. One IDLE cycle between each REPORT and the next LOAD.
- **Fairness:** after a grant to 3, Req={0,2} → grant 0 next, then 2.
- **Reset mid-RUN:** assert reset during RUN → next cycle Busy=0, Grant=0, CtrStart=1, no Done pulse. P=0, so requester 0 wins first after reset.
